// File: rtl/neuron_lif_unit.sv
// ----------------------------------------------------------------------------
// neuron_lif_unit.sv
//
// Leaky integrate-and-fire neuron with binary (+1/-1) synapses, batch-norm
// scale/offset, programmable leak shift and programmable firing threshold.
// Also holds the two helper blocks that ship with the neuron:
//   sign_extend : combinational width adapter with MSB replication
//   signal_edge : registered edge detector for control pins
//
// neuron_lif_unit ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            one integrate/fire step per enabled rising edge
//   inputs[S]         spike inputs (already masked by connectivity)
//   weights[S]        1 = +1, 0 = -1 per synapse
//   batchnorm_factor  unsigned scale in units of 0.5
//   batchnorm_addend  signed offset
//   shift             leak shift amount (0 = no leak)
//   threshold         unsigned firing threshold
//   is_spike          registered spike flag
//   membrane          debug view of the membrane potential register
// ----------------------------------------------------------------------------

// Widens (or narrows) a value by replicating its MSB.
// Ports: in[IN_WIDTH] -> out[OUT_WIDTH].
module sign_extend #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out
);
    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_widen
            assign out = {{(OUT_WIDTH-IN_WIDTH){in[IN_WIDTH-1]}}, in};
        end else if (OUT_WIDTH == IN_WIDTH) begin : g_same
            assign out = in;
        end else begin : g_narrow
            assign out = in[OUT_WIDTH-1:0];
        end
    endgenerate
endmodule

// Edge detector. prev follows signal each clock; the three pulse outputs are
// combinational from the live signal and prev, so a transition is visible in
// the same cycle it happens and lasts exactly one cycle.
// Ports: clk, reset, signal in; on_edge, on_posedge, on_negedge out.
module signal_edge (
    input  logic clk,
    input  logic reset,
    input  logic signal,
    output logic on_edge,
    output logic on_posedge,
    output logic on_negedge
);
    logic prev_q;
    logic prev_d;

    assign prev_d = signal;

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end

    assign on_posedge = signal & ~prev_q;
    assign on_negedge = ~signal & prev_q;
    assign on_edge    = signal ^ prev_q;
endmodule

module neuron_lif_unit #(
    parameter int SYNAPSES              = 16,
    parameter int THRESHOLD_BITS        = $clog2(SYNAPSES) + 1,
    parameter int BATCHNORM_ADDEND_BITS = $clog2(SYNAPSES),
    localparam int MEM_BITS             = $clog2(SYNAPSES) + 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [SYNAPSES-1:0]              inputs,
    input  logic [SYNAPSES-1:0]              weights,
    input  logic [3:0]                       batchnorm_factor,
    input  logic [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
    input  logic [2:0]                       shift,
    input  logic [THRESHOLD_BITS-1:0]        threshold,
    output logic                             is_spike,
    output logic signed [MEM_BITS-1:0]       membrane
);
    localparam int SUM_BITS = $clog2(SYNAPSES) + 2;
    // Two guard bits so u - decay + scaled can be formed exactly before
    // it is clamped back into the membrane range.
    localparam int WIDE     = MEM_BITS + 2;

    localparam logic signed [SUM_BITS-1:0] SUM_ONE = SUM_BITS'(1);
    localparam logic signed [WIDE-1:0] MEM_MAX = WIDE'((1 <<< (MEM_BITS - 1)) - 1);
    localparam logic signed [WIDE-1:0] MEM_MIN = WIDE'(-(1 <<< (MEM_BITS - 1)));

    logic signed [MEM_BITS-1:0] u_q, u_d;
    logic                       spike_q, spike_d;

    logic signed [SUM_BITS-1:0] sum;
    logic signed [WIDE-1:0]     sum_w;
    logic signed [WIDE-1:0]     factor_w;
    logic signed [WIDE-1:0]     addend_w;
    logic signed [WIDE-1:0]     scaled;
    logic signed [WIDE-1:0]     u_w;
    logic signed [WIDE-1:0]     decay;
    logic signed [WIDE-1:0]     pot_w;
    logic signed [MEM_BITS-1:0] pot_sat;
    logic signed [MEM_BITS-1:0] thr_ext;
    logic                       fire;

    sign_extend #(
        .IN_WIDTH  (BATCHNORM_ADDEND_BITS),
        .OUT_WIDTH (WIDE)
    ) u_addend_ext (
        .in  (batchnorm_addend),
        .out (addend_w)
    );

    // Synaptic sum: active synapses add +1 or -1, inactive ones nothing.
    always_comb begin
        sum = '0;
        for (int i = 0; i < SYNAPSES; i++) begin
            if (inputs[i]) begin
                sum = weights[i] ? (sum + SUM_ONE) : (sum - SUM_ONE);
            end
        end
    end

    always_comb begin
        sum_w    = {{(WIDE-SUM_BITS){sum[SUM_BITS-1]}}, sum};
        factor_w = $signed({{(WIDE-4){1'b0}}, batchnorm_factor});
        // Factor is in halves; >>> floors toward minus infinity.
        scaled   = ((sum_w * factor_w) >>> 1) + addend_w;

        u_w      = {{(WIDE-MEM_BITS){u_q[MEM_BITS-1]}}, u_q};
        // shift=0 means no leak; u >>> 0 would otherwise wipe u out.
        decay    = (shift == 3'd0) ? '0 : (u_w >>> shift);
        pot_w    = u_w - decay + scaled;

        if (pot_w > MEM_MAX)      pot_sat = MEM_MAX[MEM_BITS-1:0];
        else if (pot_w < MEM_MIN) pot_sat = MEM_MIN[MEM_BITS-1:0];
        else                      pot_sat = pot_w[MEM_BITS-1:0];

        thr_ext  = $signed({{(MEM_BITS-THRESHOLD_BITS){1'b0}}, threshold});
        fire     = (pot_sat >= thr_ext);
    end

    always_comb begin
        u_d     = u_q;
        spike_d = 1'b0;
        if (enable) begin
            spike_d = fire;
            // Reset by subtraction keeps the overshoot; pot >= thr >= 0 here,
            // so the difference cannot underflow.
            u_d     = fire ? (pot_sat - thr_ext) : pot_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            u_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            u_q     <= u_d;
            spike_q <= spike_d;
        end
    end

    assign is_spike = spike_q;
    assign membrane = u_q;
endmodule

// File: tb/tb_neuron_lif_unit.sv
module tb_neuron_lif_unit;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] inputs;
    logic [15:0] weights;
    logic [3:0]  batchnorm_factor;
    logic [3:0]  batchnorm_addend;
    logic [2:0]  shift;
    logic [4:0]  threshold;
    logic        is_spike;
    logic signed [9:0] membrane;

    logic [3:0]  se44_in, se44_out;
    logic [3:0]  se43_in;
    logic [2:0]  se43_out;
    logic        sig, on_edge, on_posedge, on_negedge;

    int checks;
    int failures;

    neuron_lif_unit #(.SYNAPSES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .inputs           (inputs),
        .weights          (weights),
        .batchnorm_factor (batchnorm_factor),
        .batchnorm_addend (batchnorm_addend),
        .shift            (shift),
        .threshold        (threshold),
        .is_spike         (is_spike),
        .membrane         (membrane)
    );

    sign_extend #(.IN_WIDTH(4), .OUT_WIDTH(4)) u_se44 (.in(se44_in), .out(se44_out));
    sign_extend #(.IN_WIDTH(4), .OUT_WIDTH(3)) u_se43 (.in(se43_in), .out(se43_out));

    signal_edge u_edge (
        .clk        (clk),
        .reset      (reset),
        .signal     (sig),
        .on_edge    (on_edge),
        .on_posedge (on_posedge),
        .on_negedge (on_negedge)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u(input string tag, input int exp_u, input int exp_spk);
        chk({tag, ".u"}, 32'(membrane), exp_u);
        chk({tag, ".spike"}, {31'd0, is_spike}, exp_spk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_edge(input string tag, input int e, input int p, input int n);
        chk({tag, ".edge"}, {31'd0, on_edge}, e);
        chk({tag, ".pos"},  {31'd0, on_posedge}, p);
        chk({tag, ".neg"},  {31'd0, on_negedge}, n);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        enable = 1'b0;
        inputs = '0;
        weights = '0;
        batchnorm_factor = '0;
        batchnorm_addend = '0;
        shift = '0;
        threshold = '0;
        sig = 1'b0;
        se44_in = '0;
        se43_in = '0;
        step();
        step();
        chk_u("reset", 0, 0);
        chk_edge("edge_reset", 0, 0, 0);

        // Integrate/fire with reset by subtraction, sum=+4, scaled=4, thr=9.
        reset = 1'b0;
        weights = 16'hFFFF;
        batchnorm_factor = 4'd2;
        batchnorm_addend = 4'd0;
        shift = 3'd0;
        threshold = 5'd9;
        inputs = 16'h000F;
        enable = 1'b1;
        step(); chk_u("pos_s1", 4, 0);
        step(); chk_u("pos_s2", 8, 0);
        step(); chk_u("pos_s3", 3, 1);
        enable = 1'b0;
        step(); chk_u("hold", 3, 0);
        step(); chk_u("hold2", 3, 0);
        enable = 1'b1;
        step(); chk_u("pos_s4", 7, 0);
        step(); chk_u("pos_s5", 2, 1);
        // Reset wins over enable.
        reset = 1'b1;
        step(); chk_u("mid_reset", 0, 0);
        reset = 1'b0;

        // Negative weights: sum -4, never fires.
        weights = 16'h0000;
        step(); chk_u("neg_s1", -4, 0);
        step(); chk_u("neg_s2", -8, 0);
        step(); chk_u("neg_s3", -12, 0);
        do_reset();

        // Leak: shift=1, one step at scaled=8, then no input.
        weights = 16'hFFFF;
        inputs = 16'h000F;
        batchnorm_factor = 4'd4;
        shift = 3'd1;
        threshold = 5'd31;
        step(); chk_u("leak_s1", 8, 0);
        inputs = 16'h0000;
        step(); chk_u("leak_s2", 4, 0);
        step(); chk_u("leak_s3", 2, 0);
        step(); chk_u("leak_s4", 1, 0);
        shift = 3'd0;
        do_reset();

        // Batch-norm: sum 4, factor 3, addend -1 -> (12>>>1)-1 = 5.
        inputs = 16'h000F;
        batchnorm_factor = 4'd3;
        batchnorm_addend = 4'hF;
        step(); chk_u("bn_f3", 5, 0);
        do_reset();

        // Factor 0, addend +7: only the addend survives.
        batchnorm_factor = 4'd0;
        batchnorm_addend = 4'd7;
        inputs = 16'hA5C3;
        weights = 16'h1234;
        step(); chk_u("bn_f0_a", 7, 0);
        inputs = 16'hFFFF;
        weights = 16'h0000;
        step(); chk_u("bn_f0_b", 14, 0);
        do_reset();

        // Floor rounding: sum -1, factor 1 -> -1.
        batchnorm_addend = 4'd0;
        batchnorm_factor = 4'd1;
        inputs = 16'h0001;
        weights = 16'h0000;
        step(); chk_u("round_s1", -1, 0);
        step(); chk_u("round_s2", -2, 0);
        do_reset();

        // Mixed weights: +4 (bits 4-7) -4 (bits 8-11) +1 (bit 3) = 1; factor 2 -> 1.
        batchnorm_factor = 4'd2;
        weights = 16'h00FF;
        inputs = 16'h0FF8;
        step(); chk_u("mixed", 1, 0);
        do_reset();

        // Positive saturation: scaled = 120, threshold 0.
        inputs = 16'hFFFF;
        weights = 16'hFFFF;
        batchnorm_factor = 4'd15;
        threshold = 5'd0;
        step(); chk_u("psat_s1", 120, 1);
        step(); chk_u("psat_s2", 240, 1);
        step(); chk_u("psat_s3", 360, 1);
        step(); chk_u("psat_s4", 480, 1);
        step(); chk_u("psat_s5", 511, 1);
        step(); chk_u("psat_s6", 511, 1);
        do_reset();

        // Negative saturation: scaled = -120.
        weights = 16'h0000;
        threshold = 5'd31;
        step(); chk_u("nsat_s1", -120, 0);
        step(); chk_u("nsat_s2", -240, 0);
        step(); chk_u("nsat_s3", -360, 0);
        step(); chk_u("nsat_s4", -480, 0);
        step(); chk_u("nsat_s5", -512, 0);
        step(); chk_u("nsat_s6", -512, 0);
        enable = 1'b0;

        // sign_extend helpers.
        se44_in = 4'h8;
        se43_in = 4'hC;
        #1;
        chk("se44", {28'd0, se44_out}, 32'h8);
        chk("se43", {29'd0, se43_out}, 32'h4);
        se44_in = 4'h5;
        se43_in = 4'h3;
        #1;
        chk("se44_b", {28'd0, se44_out}, 32'h5);
        chk("se43_b", {29'd0, se43_out}, 32'h3);

        // signal_edge: 0 -> 1 -> 1 -> 0.
        sig = 1'b1;
        #1;
        chk_edge("edge_rise", 1, 1, 0);
        step(); chk_edge("edge_high1", 0, 0, 0);
        step(); chk_edge("edge_high2", 0, 0, 0);
        sig = 1'b0;
        #1;
        chk_edge("edge_fall", 1, 0, 1);
        step(); chk_edge("edge_low", 0, 0, 0);

        // Signal already high when reset is released.
        reset = 1'b1;
        sig = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_edge("edge_post_reset", 1, 1, 0);
        step(); chk_edge("edge_post_reset2", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
